// File: rtl/store_commit_buffer_pkg.sv
// Shared definitions for the store commit buffer.
// Holds the LSB size codes, the default IO-region tag, the drain FSM state
// encoding and the size-to-byte-count mapping used when a store is accepted.
package store_commit_buffer_pkg;

  localparam int unsigned LSBINSTRLEN = 3;
  localparam int unsigned NB_W        = 3;

  localparam logic [LSBINSTRLEN-1:0] REQUIRE8  = 3'd0;
  localparam logic [LSBINSTRLEN-1:0] REQUIRE16 = 3'd1;
  localparam logic [LSBINSTRLEN-1:0] REQUIRE32 = 3'd2;

  // addr[17:16] value that marks the memory-mapped IO region
  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2
  } scb_state_e;

  // Unknown size codes are treated as full-word stores
  function automatic logic [NB_W-1:0] size_to_nbytes(input logic [LSBINSTRLEN-1:0] size);
    case (size)
      REQUIRE8:  return 3'd1;
      REQUIRE16: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/store_commit_buffer_scb_fifo.sv
// In-order storage for committed stores.
// Ports: clk/rst (sync, active-high), i_en (global ready),
//   i_push/i_addr/i_value/i_nbytes  - store written at tail,
//   i_pop                            - retire head,
//   o_head_*                         - head entry fields,
//   o_count / o_count_next_c         - occupancy now / after this cycle,
//   o_almost_full                    - registered count_next >= DEPTH-1,
//   i_query_addr / o_conflict_c      - word-address match against valid entries.
module store_commit_buffer_scb_fifo
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_value,
  input  logic [NB_W-1:0]   i_nbytes,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_query_addr,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_value,
  output logic [NB_W-1:0]   o_head_nbytes,
  output logic [CNT_W-1:0]  o_count,
  output logic [CNT_W-1:0]  o_count_next_c,
  output logic              o_almost_full,
  output logic              o_conflict_c
);

  logic [ADDR_W-1:0] r_addr   [DEPTH];
  logic [DATA_W-1:0] r_value  [DEPTH];
  logic [NB_W-1:0]   r_nbytes [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_almost_full;

  logic              w_push_ok;
  logic              w_pop_ok;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_unused_qlo;

  // A push into a completely full buffer is dropped
  assign w_push_ok    = i_en && i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop_ok     = i_en && i_pop && (r_count != '0);
  assign w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
  assign w_unused_qlo = &{1'b0, i_query_addr[1:0]};

  // Pointer, occupancy and entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_valid       <= '0;
      r_almost_full <= 1'b0;
    end else if (i_en) begin
      if (w_pop_ok) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push_ok) begin
        r_addr[r_tail]   <= i_addr;
        r_value[r_tail]  <= i_value;
        r_nbytes[r_tail] <= i_nbytes;
        r_valid[r_tail]  <= 1'b1;
        r_tail           <= r_tail + PTR_W'(1);
      end
      if (i_push) begin
        assert (r_count != CNT_W'(DEPTH))
          else $warning("store_commit_buffer: push dropped, buffer already holds DEPTH stores");
      end
      r_count       <= w_count_next;
      // One slot of slack for a commit already in flight from the ROB
      r_almost_full <= (w_count_next >= CNT_W'(DEPTH - 1));
    end
  end

  // Conservative word-granular alias check over every valid entry
  always_comb begin
    o_conflict_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][ADDR_W-1:2] == i_query_addr[ADDR_W-1:2])) begin
        o_conflict_c = 1'b1;
      end
    end
  end

  assign o_head_addr    = r_addr[r_head];
  assign o_head_value   = r_value[r_head];
  assign o_head_nbytes  = r_nbytes[r_head];
  assign o_count        = r_count;
  assign o_count_next_c = w_count_next;
  assign o_almost_full  = r_almost_full;

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer: queues committed stores from the ROB and drains them
// byte by byte to the memory controller.
// Ports: clk/rst (sync, active-high), rdy (global hold),
//   rob_enable_lsb_write/to_lsb_value/to_lsb_size/to_lsb_addr - commit input,
//   scb_full/scb_empty      - registered occupancy flags,
//   query_addr/query_conflict - combinational load alias check,
//   mem_req/mem_grant/io_buffer_full - memory port arbitration and IO stall,
//   mem_a/mem_dout/mem_wr   - registered byte write to memory.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [1:0]  IO_HI  = IO_HI_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rob_enable_lsb_write,
  input  logic [DATA_W-1:0]      to_lsb_value,
  input  logic [LSBINSTRLEN-1:0] to_lsb_size,
  input  logic [ADDR_W-1:0]      to_lsb_addr,
  output logic                   scb_full,
  output logic                   scb_empty,
  input  logic [ADDR_W-1:0]      query_addr,
  output logic                   query_conflict,
  output logic                   mem_req,
  input  logic                   mem_grant,
  input  logic                   io_buffer_full,
  output logic [ADDR_W-1:0]      mem_a,
  output logic [7:0]             mem_dout,
  output logic                   mem_wr
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  scb_state_e        r_state;
  logic [1:0]        r_k;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_scb_empty;

  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_value;
  logic [NB_W-1:0]   w_head_nbytes;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_almost_full;
  logic              w_conflict;
  logic              w_active;
  logic              w_stall;
  logic              w_last;
  logic              w_pop;
  logic              w_idle_next;
  logic [7:0]        w_byte;

  store_commit_buffer_scb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .i_en           (rdy),
    .i_push         (rob_enable_lsb_write),
    .i_addr         (to_lsb_addr),
    .i_value        (to_lsb_value),
    .i_nbytes       (size_to_nbytes(to_lsb_size)),
    .i_pop          (w_pop),
    .i_query_addr   (query_addr),
    .o_head_addr    (w_head_addr),
    .o_head_value   (w_head_value),
    .o_head_nbytes  (w_head_nbytes),
    .o_count        (w_count),
    .o_count_next_c (w_count_next),
    .o_almost_full  (w_almost_full),
    .o_conflict_c   (w_conflict)
  );

  // The grant edge in REQ doubles as the first write cycle, so byte 0 is on
  // the bus one cycle after mem_req rises.
  assign w_active    = (r_state == ST_WRITE) || ((r_state == ST_REQ) && mem_grant);
  assign w_stall     = (w_head_addr[17:16] == IO_HI) && io_buffer_full;
  assign w_last      = ({1'b0, r_k} == (w_head_nbytes - 3'd1));
  assign w_pop       = rdy && w_active && !w_stall && w_last;
  assign w_idle_next = ((r_state == ST_IDLE) && (w_count == '0)) || w_pop;
  assign w_byte      = 8'(w_head_value >> {r_k, 3'b000});

  // Drain FSM and byte serialiser
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_a     <= '0;
      r_mem_dout  <= '0;
      r_scb_empty <= 1'b1;
    end else if (rdy) begin
      r_mem_wr    <= 1'b0;
      r_scb_empty <= (w_count_next == '0) && w_idle_next;
      case (r_state)
        ST_IDLE: begin
          if (w_count != '0) begin
            r_mem_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_grant) r_state <= ST_WRITE;
        end
        ST_WRITE: r_state <= ST_WRITE;
        default:  r_state <= ST_IDLE;
      endcase
      if (w_active && !w_stall) begin
        r_mem_wr   <= 1'b1;
        r_mem_a    <= w_head_addr + ADDR_W'(r_k);
        r_mem_dout <= w_byte;
        if (w_last) begin
          // Dropping mem_req between stores lets other requesters win
          r_k       <= '0;
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end else begin
          r_k <= r_k + 2'd1;
        end
      end
    end
  end

  assign scb_full       = w_almost_full;
  assign scb_empty      = r_scb_empty;
  assign query_conflict = w_conflict;
  assign mem_req        = r_mem_req;
  assign mem_wr         = r_mem_wr;
  assign mem_a          = r_mem_a;
  assign mem_dout       = r_mem_dout;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios with literal
// expectations plus a randomized phase checked against a queue-based model.
module tb_store_commit_buffer;
  import store_commit_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_enable_lsb_write;
  logic [31:0] to_lsb_value, to_lsb_addr, query_addr, mem_a;
  logic [2:0]  to_lsb_size;
  logic        scb_full, scb_empty, query_conflict;
  logic        mem_req, mem_grant, io_buffer_full, mem_wr;
  logic [7:0]  mem_dout;

  store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rob_enable_lsb_write(rob_enable_lsb_write), .to_lsb_value(to_lsb_value),
    .to_lsb_size(to_lsb_size), .to_lsb_addr(to_lsb_addr),
    .scb_full(scb_full), .scb_empty(scb_empty),
    .query_addr(query_addr), .query_conflict(query_conflict),
    .mem_req(mem_req), .mem_grant(mem_grant), .io_buffer_full(io_buffer_full),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] value; int nb; } st_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;

  st_t mq[$];
  wr_t wlog[$];
  int  kk = 0;
  int  cyc = 0;
  int  last_push_cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  gmode = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nb_of(input logic [2:0] s);
    if (s == REQUIRE8)  return 1;
    if (s == REQUIRE16) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] v, input int k);
    logic [31:0] s;
    s = v >> (8 * k);
    return s[7:0];
  endfunction

  function automatic logic model_conflict(input logic [31:0] q);
    foreach (mq[i]) if (mq[i].addr[31:2] == q[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // Model update and per-cycle output comparison
  logic        m_armed = 1'b0;
  logic        m_rst, m_rdy, m_push, m_iof, m_head_io, m_accept;
  logic [31:0] m_a, m_v;
  logic [2:0]  m_s;
  logic        p_req, p_wr, p_full, p_empty;
  logic [31:0] p_a;
  logic [7:0]  p_d;

  always @(posedge clk) begin
    cyc++;
    m_rst  = rst;  m_rdy = rdy;  m_push = rob_enable_lsb_write;  m_iof = io_buffer_full;
    m_a    = to_lsb_addr;  m_v = to_lsb_value;  m_s = to_lsb_size;
    m_head_io = (mq.size() > 0) && (mq[0].addr[17:16] == 2'b11);
    m_accept  = m_push && (mq.size() != DEPTH);
    #1;
    if (m_rst) begin
      m_armed = 1'b1;
      mq.delete();
      kk = 0;
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_wr", 32'(mem_wr), 0);
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_dout", 32'(mem_dout), 0);
      chk("rst_scb_full", 32'(scb_full), 0);
      chk("rst_scb_empty", 32'(scb_empty), 1);
    end else if (m_armed && m_rdy) begin
      if (mem_wr) begin
        chk("wr_has_store", 32'(mq.size() != 0), 1);
        if (mq.size() != 0) begin
          chk("mem_a", mem_a, mq[0].addr + 32'(kk));
          chk("mem_dout", 32'(mem_dout), 32'(byte_of(mq[0].value, kk)));
          chk("io_stall_respected", 32'(m_iof && m_head_io), 0);
          wlog.push_back('{a: mem_a, d: mem_dout, cyc: cyc});
          kk++;
          if (kk == mq[0].nb) begin
            void'(mq.pop_front());
            kk = 0;
          end
        end
      end
      if (m_accept) begin
        mq.push_back('{addr: m_a, value: m_v, nb: nb_of(m_s)});
        last_push_cyc = cyc;
      end
      chk("scb_full", 32'(scb_full), 32'(mq.size() >= DEPTH - 1));
      chk("scb_empty", 32'(scb_empty), 32'(mq.size() == 0));
      if (mq.size() == 0) chk("mem_req_when_empty", 32'(mem_req), 0);
    end else if (m_armed) begin
      chk("hold_mem_req", 32'(mem_req), 32'(p_req));
      chk("hold_mem_wr", 32'(mem_wr), 32'(p_wr));
      chk("hold_mem_a", mem_a, p_a);
      chk("hold_mem_dout", 32'(mem_dout), 32'(p_d));
      chk("hold_scb_full", 32'(scb_full), 32'(p_full));
      chk("hold_scb_empty", 32'(scb_empty), 32'(p_empty));
    end
    p_req = mem_req;  p_wr = mem_wr;  p_a = mem_a;  p_d = mem_dout;
    p_full = scb_full;  p_empty = scb_empty;
    #1;
    if (m_armed) chk("query_conflict", 32'(query_conflict), 32'(model_conflict(query_addr)));
  end

  // Arbiter: once granted, grant stays high while mem_req is high
  initial begin
    mem_grant = 1'b0;
    forever begin
      @(negedge clk);
      case (gmode)
        0: if (!mem_req) mem_grant = 1'b0;
           else if (!mem_grant) mem_grant = ($urandom_range(0, 2) == 0);
        1: mem_grant = 1'b1;
        default: mem_grant = 1'b0;
      endcase
    end
  end

  task automatic do_push(input logic [31:0] a, input logic [31:0] v, input logic [2:0] s);
    rob_enable_lsb_write = 1'b1;
    to_lsb_addr = a;  to_lsb_value = v;  to_lsb_size = s;
    @(negedge clk);
    rob_enable_lsb_write = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int t = 0;
    while (wlog.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_timeout"}, 32'(wlog.size() >= n), 1);
  endtask

  task automatic wait_empty(input int budget, input string name);
    int t = 0;
    while (!(scb_empty && mq.size() == 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drain_timeout"}, 32'(scb_empty && mq.size() == 0), 1);
  endtask

  logic [7:0] sw_bytes [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};

  initial begin
    rst = 1'b1;  rdy = 1'b1;  rob_enable_lsb_write = 1'b0;
    to_lsb_value = '0;  to_lsb_addr = '0;  to_lsb_size = REQUIRE32;
    query_addr = '0;  io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single SW, immediate grant
    gmode = 1;  wlog.delete();
    do_push(32'h0000_1000, 32'hAABB_CCDD, REQUIRE32);
    chk("sw_req_not_yet", 32'(mem_req), 0);
    @(negedge clk);
    chk("sw_req_after_1", 32'(mem_req), 1);
    wait_log(4, 20, "sw");
    for (int i = 0; i < 4; i++) begin
      if (i < wlog.size()) begin
        chk("sw_addr", wlog[i].a, 32'h1000 + 32'(i));
        chk("sw_data", 32'(wlog[i].d), 32'(sw_bytes[i]));
        chk("sw_cycle", 32'(wlog[i].cyc), 32'(last_push_cyc + 2 + i));
      end
    end
    @(negedge clk);
    chk("sw_empty_after", 32'(scb_empty), 1);

    // SB then SH back-to-back
    wait_empty(50, "pre_sbsh");
    wlog.delete();
    do_push(32'h20, 32'hFFFF_FF12, REQUIRE8);
    do_push(32'h30, 32'hABCD_3456, REQUIRE16);
    wait_log(3, 30, "sbsh");
    if (wlog.size() >= 3) begin
      chk("sb_addr", wlog[0].a, 32'h20);
      chk("sb_data", 32'(wlog[0].d), 32'h12);
      chk("sh_addr0", wlog[1].a, 32'h30);
      chk("sh_data0", 32'(wlog[1].d), 32'h56);
      chk("sh_addr1", wlog[2].a, 32'h31);
      chk("sh_data1", 32'(wlog[2].d), 32'h34);
      chk("sbsh_req_gap", 32'(wlog[1].cyc - wlog[0].cyc >= 2), 1);
      chk("sh_consecutive", 32'(wlog[2].cyc - wlog[1].cyc), 1);
    end

    // Fill with grant held low, then a forced 5th push
    wait_empty(50, "pre_fill");
    gmode = 2;  wlog.delete();
    do_push(32'h100, 32'h0403_0201, REQUIRE32);
    do_push(32'h200, 32'h1413_1211, REQUIRE32);
    chk("full_after_2", 32'(scb_full), 0);
    do_push(32'h300, 32'h2423_2221, REQUIRE32);
    chk("full_after_3", 32'(scb_full), 1);
    do_push(32'h400, 32'h3433_3231, REQUIRE32);
    chk("full_after_4", 32'(scb_full), 1);
    do_push(32'h5000, 32'h5555_5555, REQUIRE32);
    chk("full_after_drop", 32'(scb_full), 1);
    gmode = 1;
    wait_empty(100, "fill");
    repeat (3) @(negedge clk);
    chk("fill_bytes", 32'(wlog.size()), 16);
    if (wlog.size() >= 16) begin
      chk("fill_4th_addr", wlog[12].a, 32'h400);
      chk("fill_last_data", 32'(wlog[15].d), 32'h34);
    end

    // IO stall for 3 write opportunities
    wlog.delete();
    io_buffer_full = 1'b1;
    do_push(32'h0003_0000, 32'h0000_0041, REQUIRE8);
    repeat (4) begin
      @(negedge clk);
      chk("io_stall_wr", 32'(mem_wr), 0);
    end
    io_buffer_full = 1'b0;
    wait_log(1, 20, "io");
    if (wlog.size() >= 1) begin
      chk("io_addr", wlog[0].a, 32'h0003_0000);
      chk("io_data", 32'(wlog[0].d), 32'h41);
      chk("io_cycle", 32'(wlog[0].cyc), 32'(last_push_cyc + 5));
    end
    repeat (3) @(negedge clk);
    chk("io_single_write", 32'(wlog.size()), 1);

    // Address conflict
    wait_empty(50, "pre_conf");
    gmode = 2;
    do_push(32'h1004, 32'h0, REQUIRE32);
    query_addr = 32'h1006;  #1;
    chk("conf_same_word", 32'(query_conflict), 1);
    query_addr = 32'h1008;  #1;
    chk("conf_next_word", 32'(query_conflict), 0);
    query_addr = 32'h1003;  #1;
    chk("conf_prev_word", 32'(query_conflict), 0);
    gmode = 1;
    wait_empty(50, "conf");
    @(negedge clk);
    query_addr = 32'h1006;  #1;
    chk("conf_after_drain", 32'(query_conflict), 0);

    // Reset after the second byte of an SW
    @(negedge clk);
    wlog.delete();
    do_push(32'h2000, 32'h1122_3344, REQUIRE32);
    wait_log(2, 20, "rst_mid");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr", 32'(mem_wr), 0);
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_empty", 32'(scb_empty), 1);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_more", 32'(wlog.size()), 2);

    // Randomized traffic
    gmode = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if ((!scb_full || $urandom_range(0, 49) == 0) && $urandom_range(0, 1) == 1) begin
        rob_enable_lsb_write = 1'b1;
        case ($urandom_range(0, 3))
          0: to_lsb_addr = {14'h0, 2'b11, 16'($urandom)};
          1: to_lsb_addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          default: to_lsb_addr = $urandom;
        endcase
        to_lsb_value = $urandom;
        to_lsb_size  = 3'($urandom_range(0, 7));
      end else begin
        rob_enable_lsb_write = 1'b0;
      end
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        query_addr = mq[$urandom_range(0, mq.size() - 1)].addr ^ 32'($urandom_range(0, 7));
      else
        query_addr = $urandom;
      @(negedge clk);
    end
    rst = 1'b0;  rdy = 1'b1;  io_buffer_full = 1'b0;  rob_enable_lsb_write = 1'b0;
    gmode = 1;
    wait_empty(200, "random");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
